gray_dec_arbiter: RTL and testbench

Round-robin scheduler that shares one registered Gray-to-binary decode stage among `N_REQ` requesters, such as rotary encoders or Gray-coded counters. Each requester presents a Gray word with a valid/ready handshake. The block grants one requester at a time, decodes the word, and presents the binary result with the requester ID on a single valid/ready output port. It sits between the Gray-coded sources and the downstream binary consumers.

---
 rtl/gray_dec_arbiter.sv | 148 ++++++++++++++
 tb/tb_gray_dec_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gray_dec_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : gray_dec_arbiter
// Purpose  : Round-robin arbiter that shares one registered Gray-to-binary
//            decode stage among N_REQ valid/ready requesters.
// Option   : define GRAY_DEC_STEP_CHK_EN to add the per-requester step check
//            and the err output.
// Revision : 1.0 - initial release
// ============================================================================
module gray_dec_arbiter #(
    parameter int N_REQ = 4,
    parameter int W     = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [N_REQ*W-1:0]       req_gray,
    output logic [N_REQ-1:0]         req_ready,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [W-1:0]             out_bin,
    output logic [$clog2(N_REQ)-1:0] out_id,
`ifdef GRAY_DEC_STEP_CHK_EN
    output logic                     err,
`endif
    output logic                     busy
);
    localparam int IDW = $clog2(N_REQ);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t         state;
    state_t         state_next;
    logic [IDW-1:0] ptr;
    logic [IDW-1:0] id_q;
    logic [IDW-1:0] cand;
    logic [IDW-1:0] grant_idx;
    logic           grant_found;
    logic [W-1:0]   gray_q;
    logic [W-1:0]   bin_next;
    logic           xor_acc;

    // First valid requester at or above ptr, wrapping modulo N_REQ.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = IDW'((32'(ptr) + 32'(k)) % 32'(N_REQ));
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    // Binary bit k is the XOR of all Gray bits from the MSB down to k.
    always_comb begin
        xor_acc  = 1'b0;
        bin_next = '0;
        for (int k = W - 1; k >= 0; k--) begin
            xor_acc     = xor_acc ^ gray_q[k];
            bin_next[k] = xor_acc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        req_ready  = '0;
        case (state)
            IDLE: begin
                if (grant_found && !rst) begin
                    req_ready[grant_idx] = 1'b1;
                    state_next           = CONV;
                end
            end
            CONV:    state_next = HOLD;
            HOLD:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr       <= '0;
            gray_q    <= '0;
            id_q      <= '0;
            out_valid <= 1'b0;
            out_bin   <= '0;
            out_id    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_found) begin
                        gray_q <= req_gray[int'(grant_idx) * W +: W];
                        id_q   <= grant_idx;
                        ptr    <= IDW'((32'(grant_idx) + 32'd1) % 32'(N_REQ));
                    end
                end
                CONV: begin
                    out_bin   <= bin_next;
                    out_id    <= id_q;
                    out_valid <= 1'b1;
                end
                HOLD: begin
                    if (out_ready) out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

`ifdef GRAY_DEC_STEP_CHK_EN
    logic [W-1:0]     last_gray [N_REQ];
    logic [N_REQ-1:0] seen;

    // A step of more than one bit since the requester's previous word is an error.
    always_ff @(posedge clk) begin
        if (rst) begin
            err  <= 1'b0;
            seen <= '0;
            for (int i = 0; i < N_REQ; i++) last_gray[i] <= '0;
        end else if (state == CONV) begin
            err             <= seen[id_q] && ($countones(gray_q ^ last_gray[id_q]) > 1);
            last_gray[id_q] <= gray_q;
            seen[id_q]      <= 1'b1;
        end
    end
`else
    // Default build carries no per-requester history.
`endif

endmodule
`default_nettype wire

// File: tb/tb_gray_dec_arbiter.sv
`default_nettype none
// Testbench for gray_dec_arbiter: directed vector table, corner-case sequences
// and a randomized run against a transaction-level reference model.
module tb_gray_dec_arbiter;
    localparam int N = 4;
    localparam int W = 4;

    logic        clk       = 1'b0;
    logic        rst       = 1'b1;
    logic [3:0]  req_valid = '0;
    logic [15:0] req_gray  = '0;
    logic        out_ready = 1'b0;
    logic [3:0]  req_ready;
    logic        out_valid;
    logic [3:0]  out_bin;
    logic [1:0]  out_id;
    logic        busy;
`ifdef GRAY_DEC_STEP_CHK_EN
    logic        err;
`endif

    gray_dec_arbiter #(.N_REQ(N), .W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_gray  (req_gray),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bin   (out_bin),
        .out_id    (out_id),
`ifdef GRAY_DEC_STEP_CHK_EN
        .err       (err),
`endif
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int         ch;
        logic [3:0] gray;
        logic [3:0] bin;
        int         id;
    } vec_t;
    vec_t tbl [19];

    // Reference model state for the randomized run.
    int         m_ptr;
    bit         infl;
    int         acc;
    int         g;
    bit         ev;
    logic [3:0] exp_rdy;
    logic [3:0] word;
    logic [3:0] m_bin;
    logic [3:0] sh_bin;
    int         m_id;
    int         sh_id;
    logic       got_err;
`ifdef GRAY_DEC_STEP_CHK_EN
    logic       m_err;
    logic [3:0] lastg [4];
    bit         seen  [4];
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        out_ready = 1'b0;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    // Inverse Gray map found by searching the forward map b ^ (b >> 1).
    function automatic logic [3:0] g2b(input logic [3:0] gw);
        logic [3:0] b;
        for (int i = 0; i < 16; i++) begin
            b = 4'(i);
            if ((b ^ (b >> 1)) == gw) return b;
        end
        return '0;
    endfunction

    function automatic int rr(input int p, input logic [3:0] v);
        for (int k = 0; k < 4; k++) if (v[(p + k) % 4]) return (p + k) % 4;
        return -1;
    endfunction

    // One isolated transaction with out_ready high; returns err of the result.
    task automatic send_one(input int ch, input logic [3:0] gw, input logic [3:0] eb,
                            input int eid, output logic e);
        req_valid = 4'(1 << ch);
        req_gray[ch*W +: W] = gw;
        out_ready = 1'b1;
        @(negedge clk);
        check("grant", req_ready, 32'(1 << ch));
        check("idle_busy", busy, 0);
        cyc();
        req_valid = '0;
        @(negedge clk);
        check("conv_valid", out_valid, 0);
        check("conv_busy", busy, 1);
        cyc();
        @(negedge clk);
        check("out_valid", out_valid, 1);
        check("out_bin", out_bin, eb);
        check("out_id", out_id, eid);
        e = 1'b0;
`ifdef GRAY_DEC_STEP_CHK_EN
        e = err;
`endif
        cyc();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{2, 4'b1011, 4'b1101, 2};
        tbl[1] = '{0, 4'b1000, 4'b1111, 0};
        tbl[2] = '{0, 4'b0110, 4'b0100, 0};
        for (int b = 0; b < 16; b++) begin
            word = 4'(b);
            tbl[3 + b] = '{0, word ^ (word >> 1), word, 0};
        end

        // Reset values
        rst = 1'b1;
        cyc();
        cyc();
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_bin", out_bin, 0);
        check("rst_out_id", out_id, 0);
        check("rst_busy", busy, 0);
        check("rst_req_ready", req_ready, 0);
`ifdef GRAY_DEC_STEP_CHK_EN
        check("rst_err", err, 0);
`endif
        cyc();
        rst = 1'b0;

`ifdef GRAY_DEC_STEP_CHK_EN
        send_one(1, 4'b0000, g2b(4'b0000), 1, got_err);
        check("step_first", got_err, 0);
        send_one(1, 4'b0011, g2b(4'b0011), 1, got_err);
        check("step_two_bits", got_err, 1);
        send_one(1, 4'b0000, g2b(4'b0000), 1, got_err);
        check("step_back", got_err, 1);
        send_one(1, 4'b0001, g2b(4'b0001), 1, got_err);
        check("step_one_bit", got_err, 0);
        send_one(1, 4'b0001, g2b(4'b0001), 1, got_err);
        check("step_repeat", got_err, 0);
`endif

        for (int i = 0; i < 19; i++) send_one(tbl[i].ch, tbl[i].gray, tbl[i].bin, tbl[i].id, got_err);

        // Contention: all requesters valid from reset
        rst       = 1'b1;
        req_valid = 4'hF;
        req_gray  = 16'h8421;
        out_ready = 1'b1;
        @(negedge clk);
        check("rst_gate_ready", req_ready, 0);
        cyc();
        rst = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            check("rr_ready", req_ready, (i % 3 == 0) ? 32'(1 << ((i / 3) % 4)) : 32'd0);
            if (i % 3 == 2) begin
                check("rr_valid", out_valid, 1);
                check("rr_id", out_id, (i / 3) % 4);
            end
            cyc();
        end

        // Backpressure: five stalled HOLD cycles
        do_reset();
        req_valid = 4'b0010;
        req_gray  = 16'h0070;
        @(negedge clk);
        check("bp_grant", req_ready, 4'b0010);
        cyc();
        req_valid = 4'hF;
        @(negedge clk);
        check("bp_conv_busy", busy, 1);
        cyc();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_valid", out_valid, 1);
            check("bp_bin", out_bin, 4'b0101);
            check("bp_id", out_id, 1);
            check("bp_ready", req_ready, 0);
            check("bp_busy", busy, 1);
            cyc();
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_last_valid", out_valid, 1);
        cyc();
        @(negedge clk);
        check("bp_dropped", out_valid, 0);
        check("bp_held_bin", out_bin, 4'b0101);
        check("bp_next_grant", req_ready, 4'b0100);

        // Reset during CONV discards the word and returns ptr to 0
        do_reset();
        req_valid = 4'b0001;
        req_gray  = 16'h0003;
        out_ready = 1'b1;
        @(negedge clk);
        check("mid_grant", req_ready, 4'b0001);
        cyc();
        req_valid = '0;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("mid_no_valid", out_valid, 0);
            check("mid_busy", busy, 0);
            check("mid_bin", out_bin, 0);
            cyc();
        end
        req_valid = 4'b1001;
        @(negedge clk);
        check("mid_ptr_zero", req_ready, 4'b0001);
        cyc();
        req_valid = '0;
        cyc();
        cyc();

        // Randomized run against the reference model
        do_reset();
        m_ptr  = 0;
        infl   = 1'b0;
        acc    = 0;
        m_bin  = '0;
        m_id   = 0;
        sh_bin = '0;
        sh_id  = 0;
`ifdef GRAY_DEC_STEP_CHK_EN
        m_err = 1'b0;
        for (int i = 0; i < 4; i++) begin
            lastg[i] = '0;
            seen[i]  = 1'b0;
        end
`endif
        for (int c = 0; c < 400; c++) begin
            req_valid = 4'($urandom_range(0, 15));
            req_gray  = 16'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            exp_rdy = '0;
            g = -1;
            if (!infl && req_valid != 0) begin
                g = rr(m_ptr, req_valid);
                exp_rdy = 4'(1 << g);
            end
            ev = infl && (c >= acc + 2);
            check("rnd_ready", req_ready, exp_rdy);
            check("rnd_busy", busy, infl);
            check("rnd_valid", out_valid, ev);
            check("rnd_bin", out_bin, sh_bin);
            check("rnd_id", out_id, sh_id);
`ifdef GRAY_DEC_STEP_CHK_EN
            if (ev) check("rnd_err", err, m_err);
`endif
            if (infl && c == acc + 1) begin
                sh_bin = m_bin;
                sh_id  = m_id;
            end else if (ev && out_ready) begin
                infl = 1'b0;
            end else if (g >= 0) begin
                infl  = 1'b1;
                acc   = c;
                word  = req_gray[g*W +: W];
                m_bin = g2b(word);
                m_id  = g;
                m_ptr = (g + 1) % 4;
`ifdef GRAY_DEC_STEP_CHK_EN
                m_err    = seen[g] && ($countones(word ^ lastg[g]) > 1);
                lastg[g] = word;
                seen[g]  = 1'b1;
`endif
            end
            cyc();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
